// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the parametrised serial-to-parallel lane converter.
// Contents:
//   state_t      - lock FSM encoding (SEARCH, COUNT, ACTIVE)
//   DEFAULT_COM  - default 8-bit alignment symbol
//   DEFAULT_IDLE - default 8-bit filler symbol
//   clog2()      - counter width helper, never returns less than one bit
package serial_paralelo_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      COUNT  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [7:0] DEFAULT_COM  = 8'hBC;
   localparam logic [7:0] DEFAULT_IDLE = 8'h7C;

   // Bits needed to hold value-1; one bit minimum so zero-sized vectors never appear.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Lane bus between the serial input, the converter and the byte-stream consumer.
// Signals:
//   data_in   - serial bit, MSB of each symbol first
//   data_out  - last deserialised symbol (WIDTH bits)
//   valid_out - data_out carries payload
//   word_stb  - one-cycle pulse when data_out/valid_out update
//   active    - lane locked
//   unlock    - one-cycle pulse when lock is lost through the gap limit
// Modports: master drives the serial bit and observes results; slave is the converter.
interface serial_paralelo_if #(
   parameter int WIDTH = 8
);
   logic             data_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             word_stb;
   logic             active;
   logic             unlock;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  word_stb,
      input  active,
      input  unlock
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output word_stb,
      output active,
      output unlock
   );
endinterface

// File: rtl/serial_paralelo_window.sv
// Sliding bit window and symbol phase counter.
// Ports:
//   clk       - bit clock
//   reset     - synchronous active-high reset
//   data_in   - serial bit
//   phase_clr - restart the symbol phase so the next bit is bit 0 of a symbol
//   nw        - window including the bit sampled this cycle (MSB = oldest)
//   boundary  - this cycle's bit completes a symbol
module serial_paralelo_window
   import serial_paralelo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data_in,
   input  logic             phase_clr,
   output logic [WIDTH-1:0] nw,
   output logic             boundary
);
   localparam int             BW   = clog2(WIDTH);
   localparam logic [BW-1:0]  LAST = BW'(WIDTH - 1);

   // Only WIDTH-1 history bits are stored; the newest bit comes straight from data_in.
   logic [WIDTH-2:0] sr_r;
   logic [BW-1:0]    bit_cnt_r;

   assign nw       = {sr_r, data_in};
   assign boundary = (bit_cnt_r == LAST);

   // Shift the window every cycle and step the symbol phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_r      <= {(WIDTH-1){1'b0}};
         bit_cnt_r <= {BW{1'b0}};
      end else begin
         sr_r <= nw[WIDTH-2:0];
         if (phase_clr || boundary) begin
            bit_cnt_r <= {BW{1'b0}};
         end else begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
         end
      end
   end

endmodule

// File: rtl/serial_paralelo_param.sv
// Parametrised serial-to-parallel lane converter with bit-level COM alignment.
// Ports:
//   clk_32f - bit clock, all state updates on the rising edge
//   reset   - synchronous active-high reset
//   lane    - slave side of serial_paralelo_if (data_in in; data_out, valid_out,
//             word_stb, active, unlock out; all outputs registered)
module serial_paralelo_param
   import serial_paralelo_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] COM_SYMBOL  = WIDTH'(DEFAULT_COM),
   parameter logic [WIDTH-1:0] IDLE_SYMBOL = WIDTH'(DEFAULT_IDLE),
   parameter int               LOCK_COUNT  = 4,
   parameter int               MAX_GAP     = 16
) (
   input  logic             clk_32f,
   input  logic             reset,
   serial_paralelo_if.slave lane
);
   localparam int            CW          = clog2(LOCK_COUNT + 1);
   localparam int            GW          = clog2(MAX_GAP + 1);
   localparam logic [CW-1:0] LOCK_TARGET = CW'(LOCK_COUNT);
   localparam logic [GW-1:0] GAP_LIMIT   = GW'(MAX_GAP);

   state_t           state_r, state_nxt;
   logic [CW-1:0]    com_cnt_r, com_cnt_nxt;
   logic [GW-1:0]    gap_cnt_r, gap_cnt_nxt;
   logic [WIDTH-1:0] data_r, data_nxt;
   logic             valid_r, valid_nxt;
   logic             stb_r, stb_nxt;
   logic             active_r, active_nxt;
   logic             unlock_r, unlock_nxt;
   logic             phase_clr_s;
   logic [WIDTH-1:0] nw_s;
   logic             boundary_s;
   logic             is_com_s;

   serial_paralelo_window #(.WIDTH(WIDTH)) u_window (
      .clk       (clk_32f),
      .reset     (reset),
      .data_in   (lane.data_in),
      .phase_clr (phase_clr_s),
      .nw        (nw_s),
      .boundary  (boundary_s)
   );

   assign is_com_s = (nw_s == COM_SYMBOL);

   // Lock FSM next state and output-register next values.
   always_comb begin
      state_nxt   = state_r;
      com_cnt_nxt = com_cnt_r;
      gap_cnt_nxt = gap_cnt_r;
      data_nxt    = data_r;
      valid_nxt   = valid_r;
      stb_nxt     = 1'b0;
      active_nxt  = active_r;
      unlock_nxt  = 1'b0;
      phase_clr_s = 1'b0;
      case (state_r)
         SEARCH: begin
            valid_nxt = 1'b0;
            if (is_com_s) begin
               // A COM at any bit offset defines the symbol phase from here on.
               phase_clr_s = 1'b1;
               com_cnt_nxt = CW'(1);
               if (LOCK_COUNT == 32'sd1) begin
                  state_nxt   = ACTIVE;
                  active_nxt  = 1'b1;
                  gap_cnt_nxt = {GW{1'b0}};
               end else begin
                  state_nxt = COUNT;
               end
            end else begin
               state_nxt = SEARCH;
            end
         end
         COUNT: begin
            valid_nxt = 1'b0;
            if (boundary_s) begin
               if (is_com_s) begin
                  com_cnt_nxt = com_cnt_r + CW'(1);
                  if ((com_cnt_r + CW'(1)) == LOCK_TARGET) begin
                     state_nxt   = ACTIVE;
                     active_nxt  = 1'b1;
                     gap_cnt_nxt = {GW{1'b0}};
                  end else begin
                     state_nxt = COUNT;
                  end
               end else begin
                  // Alignment broken: search restarts on the next cycle.
                  state_nxt   = SEARCH;
                  com_cnt_nxt = {CW{1'b0}};
               end
            end else begin
               state_nxt = COUNT;
            end
         end
         ACTIVE: begin
            if (boundary_s) begin
               data_nxt  = nw_s;
               valid_nxt = (nw_s != COM_SYMBOL) && (nw_s != IDLE_SYMBOL);
               stb_nxt   = 1'b1;
               if (is_com_s) begin
                  gap_cnt_nxt = {GW{1'b0}};
               end else if ((GAP_LIMIT != {GW{1'b0}}) && ((gap_cnt_r + GW'(1)) == GAP_LIMIT)) begin
                  // The symbol that hits the gap limit is still presented.
                  state_nxt   = SEARCH;
                  active_nxt  = 1'b0;
                  unlock_nxt  = 1'b1;
                  com_cnt_nxt = {CW{1'b0}};
                  gap_cnt_nxt = {GW{1'b0}};
               end else if (GAP_LIMIT != {GW{1'b0}}) begin
                  gap_cnt_nxt = gap_cnt_r + GW'(1);
               end else begin
                  // Lock loss disabled: counter stays parked so it cannot wrap.
                  gap_cnt_nxt = gap_cnt_r;
               end
            end else begin
               state_nxt = ACTIVE;
            end
         end
         default: begin
            state_nxt   = SEARCH;
            com_cnt_nxt = {CW{1'b0}};
            gap_cnt_nxt = {GW{1'b0}};
            valid_nxt   = 1'b0;
            active_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides everything.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_r   <= SEARCH;
         com_cnt_r <= {CW{1'b0}};
         gap_cnt_r <= {GW{1'b0}};
         data_r    <= {WIDTH{1'b0}};
         valid_r   <= 1'b0;
         stb_r     <= 1'b0;
         active_r  <= 1'b0;
         unlock_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         com_cnt_r <= com_cnt_nxt;
         gap_cnt_r <= gap_cnt_nxt;
         data_r    <= data_nxt;
         valid_r   <= valid_nxt;
         stb_r     <= stb_nxt;
         active_r  <= active_nxt;
         unlock_r  <= unlock_nxt;
      end
   end

   assign lane.data_out  = data_r;
   assign lane.valid_out = valid_r;
   assign lane.word_stb  = stb_r;
   assign lane.active    = active_r;
   assign lane.unlock    = unlock_r;

endmodule
